// File: rtl/instruction_fetch_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_if
// Groups every non-clock signal of the fetch stage into one bundle.
//   Instruction-memory side : ImemReq, ImemAddr (fetch -> mem),
//                             ImemReady, ImemData (mem -> fetch)
//   Hazard/branch control   : Stall, BranchTaken, BranchTarget (-> fetch)
//   IF/ID register outputs  : InstrOut, OpcodeOut, PcPlus4Out, InstrValid
//   Optional perf counters  : FetchCount, FlushCount (only with IFETCH_PERF_EN)
// Modports: master = the fetch stage, slave = its environment.
// Optional feature macro: IFETCH_PERF_EN
// -----------------------------------------------------------------------------
interface instruction_fetch_if #(
    parameter int PC_WIDTH = 32
);
    logic                ImemReq;
    logic [PC_WIDTH-1:0] ImemAddr;
    logic                ImemReady;
    logic [31:0]         ImemData;
    logic                Stall;
    logic                BranchTaken;
    logic [PC_WIDTH-1:0] BranchTarget;
    logic [31:0]         InstrOut;
    logic [5:0]          OpcodeOut;
    logic [PC_WIDTH-1:0] PcPlus4Out;
    logic                InstrValid;
`ifdef IFETCH_PERF_EN
    logic [31:0]         FetchCount;
    logic [15:0]         FlushCount;
`endif

    modport master (
        input  ImemReady, ImemData, Stall, BranchTaken, BranchTarget,
`ifdef IFETCH_PERF_EN
        output FetchCount, FlushCount,
`endif
        output ImemReq, ImemAddr, InstrOut, OpcodeOut, PcPlus4Out, InstrValid
    );

    modport slave (
        output ImemReady, ImemData, Stall, BranchTaken, BranchTarget,
`ifdef IFETCH_PERF_EN
        input  FetchCount, FlushCount,
`endif
        input  ImemReq, ImemAddr, InstrOut, OpcodeOut, PcPlus4Out, InstrValid
    );
endinterface

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Fetch stage feeding the main decoder. Owns the PC, requests instructions
// from instruction memory with a req/ready handshake, and holds the IF/ID
// register. A one-entry buffer catches a word that arrives while the hazard
// unit is stalling, so nothing is lost or fetched twice.
// Ports:
//   Clk    in  rising-edge clock
//   Reset  in  asynchronous, active-high
//   bus    instruction_fetch_if.master (memory handshake, stall/branch
//          inputs, IF/ID outputs, optional perf counters)
// Parameters: PC_WIDTH (PC width), RESET_PC (word-aligned reset PC).
// Optional feature macro: IFETCH_PERF_EN adds saturating FetchCount and
// FlushCount counters on the interface.
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                Clk,
    input  logic                Reset,
    instruction_fetch_if.master bus
);
    typedef enum logic {FETCH, HOLD} state_e;

    localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d, pc_plus4;
    logic [31:0]         instr_q, instr_d;
    logic [PC_WIDTH-1:0] pcp4_q, pcp4_d;
    logic                valid_q, valid_d;
    logic [31:0]         buf_instr_q, buf_instr_d;
    logic [PC_WIDTH-1:0] buf_pcp4_q, buf_pcp4_d;
    // Held low during reset and for the first cycle after it, so the first
    // request appears one cycle after Reset falls.
    logic                req_en_q;

    assign pc_plus4 = pc_q + PC_STEP;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        pcp4_d      = pcp4_q;
        valid_d     = valid_q;
        buf_instr_d = buf_instr_q;
        buf_pcp4_d  = buf_pcp4_q;

        if (bus.BranchTaken) begin
            // Redirect wins over everything: drop buffer and any same-cycle data.
            pc_d    = bus.BranchTarget & ALIGN_MASK;
            instr_d = '0;
            valid_d = 1'b0;
            state_d = FETCH;
        end else if (state_q == HOLD) begin
            if (!bus.Stall) begin
                instr_d = buf_instr_q;
                pcp4_d  = buf_pcp4_q;
                valid_d = 1'b1;
                state_d = FETCH;
            end
        end else if (req_en_q && bus.ImemReady) begin
            pc_d = pc_plus4;
            if (!bus.Stall) begin
                instr_d = bus.ImemData;
                pcp4_d  = pc_plus4;
                valid_d = 1'b1;
            end else begin
                buf_instr_d = bus.ImemData;
                buf_pcp4_d  = pc_plus4;
                state_d     = HOLD;
            end
        end else if (!bus.Stall) begin
            // Memory not ready and decoder free: insert a nop bubble.
            instr_d = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            pcp4_q   <= '0;
            valid_q  <= 1'b0;
            req_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pcp4_q   <= pcp4_d;
            valid_q  <= valid_d;
            req_en_q <= 1'b1;
        end
    end

    // Buffer contents are only meaningful in HOLD, so they need no reset.
    always_ff @(posedge Clk) begin
        buf_instr_q <= buf_instr_d;
        buf_pcp4_q  <= buf_pcp4_d;
    end

    assign bus.ImemReq    = req_en_q && (state_q == FETCH);
    assign bus.ImemAddr   = pc_q;
    assign bus.InstrOut   = instr_q;
    assign bus.OpcodeOut  = instr_q[31:26];
    assign bus.PcPlus4Out = pcp4_q;
    assign bus.InstrValid = valid_q;

`ifdef IFETCH_PERF_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    logic [31:0] fetch_cnt_q;
    logic [15:0] flush_cnt_q;
    logic        load_valid;

    // IF/ID receives a real instruction: from the buffer or straight from memory.
    assign load_valid = !bus.BranchTaken && !bus.Stall &&
                        ((state_q == HOLD) || (req_en_q && bus.ImemReady));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (load_valid)      fetch_cnt_q <= sat_inc32(fetch_cnt_q);
            if (bus.BranchTaken) flush_cnt_q <= sat_inc16(flush_cnt_q);
        end
    end

    assign bus.FetchCount = fetch_cnt_q;
    assign bus.FlushCount = flush_cnt_q;
`else
    // Performance counters not built.
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
    localparam int W = 32;

    logic Clk = 1'b0;
    logic Reset0;
    logic Reset1;
    always #5 Clk = ~Clk;

    instruction_fetch_if #(.PC_WIDTH(W)) bus0();
    instruction_fetch_if #(.PC_WIDTH(W)) bus1();

    instruction_fetch #(.PC_WIDTH(W), .RESET_PC(32'h0000_0000)) dut0 (
        .Clk(Clk), .Reset(Reset0), .bus(bus0.master)
    );
    instruction_fetch #(.PC_WIDTH(W), .RESET_PC(32'hFFFF_FFFC)) dut1 (
        .Clk(Clk), .Reset(Reset1), .bus(bus1.master)
    );

    // Memory image: every word address holds a distinct non-zero pattern.
    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F17;
    endfunction

    assign bus0.ImemData = memw(bus0.ImemAddr);
    assign bus1.ImemData = memw(bus1.ImemAddr);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive0(input logic rdy, input logic st, input logic br, input logic [31:0] tgt);
        bus0.ImemReady    = rdy;
        bus0.Stall        = st;
        bus0.BranchTaken  = br;
        bus0.BranchTarget = tgt;
    endtask

    task automatic chk_reset0(input string tag);
        chk({tag, " req"},    32'(bus0.ImemReq), 32'h0);
        chk({tag, " addr"},   bus0.ImemAddr, 32'h0);
        chk({tag, " valid"},  32'(bus0.InstrValid), 32'h0);
        chk({tag, " instr"},  bus0.InstrOut, 32'h0);
        chk({tag, " pcp4"},   bus0.PcPlus4Out, 32'h0);
`ifdef IFETCH_PERF_EN
        chk({tag, " fcount"}, bus0.FetchCount, 32'h0);
        chk({tag, " flcount"}, 32'(bus0.FlushCount), 32'h0);
`endif
    endtask

    // ---------------- table-driven directed vectors ----------------
    typedef struct {
        logic        rdy, st, br;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pcp4;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic rdy, input logic st, input logic br, input logic [31:0] tgt,
                       input logic req, input logic [31:0] addr, input logic vld, input logic [31:0] pcp4);
        vec_t v;
        v.rdy = rdy; v.st = st; v.br = br; v.tgt = tgt;
        v.req = req; v.addr = addr; v.vld = vld; v.pcp4 = pcp4;
        tbl.push_back(v);
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct { logic [31:0] instr; logic [31:0] pcp4; } ent_t;
    logic [31:0] m_pc, m_instr, m_pcp4;
    logic        m_valid, m_started;
    ent_t        m_buf[$];
    int unsigned m_fc;
    int unsigned m_flc;

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pcp4 = 32'h0;
        m_valid = 1'b0; m_started = 1'b0;
        m_buf.delete();
        m_fc = 0; m_flc = 0;
    endtask

    task automatic model_step(input logic rdy, input logic st, input logic br, input logic [31:0] tgt);
        ent_t e;
        if (br) begin
            m_pc = {tgt[31:2], 2'b00};
            m_instr = 32'h0; m_valid = 1'b0;
            m_buf.delete();
            if (m_flc < 65535) m_flc++;
        end else if (m_buf.size() > 0) begin
            if (!st) begin
                e = m_buf.pop_front();
                m_instr = e.instr; m_pcp4 = e.pcp4; m_valid = 1'b1;
                if (m_fc < 32'hFFFF_FFFF) m_fc++;
            end
        end else if (m_started && rdy) begin
            if (!st) begin
                m_instr = memw(m_pc); m_pcp4 = m_pc + 32'd4; m_valid = 1'b1;
                if (m_fc < 32'hFFFF_FFFF) m_fc++;
            end else begin
                e.instr = memw(m_pc); e.pcp4 = m_pc + 32'd4;
                m_buf.push_back(e);
            end
            m_pc = m_pc + 32'd4;
        end else if (!st) begin
            m_instr = 32'h0; m_valid = 1'b0;
        end
        m_started = 1'b1;
    endtask

    initial begin
        logic rdy, st, br;
        logic [31:0] tgt, exp_instr;

        //        rdy   st    br    tgt            req   addr          vld   pcp4
        add(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h00,  1'b0, 32'h0);   // no request yet: ready ignored
        add(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h04,  1'b1, 32'h04);
        add(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h08,  1'b1, 32'h08);
        add(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0C,  1'b1, 32'h08);  // stall at PC=8 -> HOLD
        add(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0C,  1'b1, 32'h08);
        add(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0C,  1'b1, 32'h0C);  // buffered word@8 released
        add(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h10);
        add(1'b1, 1'b1, 1'b1, 32'h40,  1'b1, 32'h40,  1'b0, 32'h0);   // branch beats stall
        add(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h44,  1'b1, 32'h44);
        add(1'b0, 1'b0, 1'b1, 32'h43,  1'b1, 32'h40,  1'b0, 32'h0);   // misaligned target
        add(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h44,  1'b1, 32'h44);
        add(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h44,  1'b0, 32'h0);   // bubbles
        add(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h44,  1'b0, 32'h0);
        add(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h44,  1'b0, 32'h0);
        add(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h48,  1'b1, 32'h48);
        add(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h48,  1'b1, 32'h48);  // not ready + stall: hold
        add(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h4C,  1'b1, 32'h48);  // HOLD with word@0x48
        add(1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0);   // branch discards buffer
        add(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h104);

        Reset0 = 1'b1; Reset1 = 1'b1;
        drive0(1'b0, 1'b0, 1'b0, 32'h0);
        bus1.ImemReady = 1'b1; bus1.Stall = 1'b0;
        bus1.BranchTaken = 1'b0; bus1.BranchTarget = 32'h0;
        repeat (2) @(posedge Clk);
        #1;
        chk_reset0("reset");
        chk("wrap reset addr", bus1.ImemAddr, 32'hFFFF_FFFC);
        chk("wrap reset req", 32'(bus1.ImemReq), 32'h0);
        Reset0 = 1'b0; Reset1 = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive0(tbl[i].rdy, tbl[i].st, tbl[i].br, tbl[i].tgt);
            @(posedge Clk);
            #1;
            exp_instr = tbl[i].vld ? memw(tbl[i].pcp4 - 32'd4) : 32'h0;
            chk($sformatf("vec%0d req", i),   32'(bus0.ImemReq), 32'(tbl[i].req));
            chk($sformatf("vec%0d addr", i),  bus0.ImemAddr, tbl[i].addr);
            chk($sformatf("vec%0d valid", i), 32'(bus0.InstrValid), 32'(tbl[i].vld));
            chk($sformatf("vec%0d instr", i), bus0.InstrOut, exp_instr);
            chk($sformatf("vec%0d opcode", i), 32'(bus0.OpcodeOut), 32'(exp_instr[31:26]));
            if (tbl[i].vld)
                chk($sformatf("vec%0d pcp4", i), bus0.PcPlus4Out, tbl[i].pcp4);
            if (i == 0) begin
                chk("wrap first req", 32'(bus1.ImemReq), 32'h1);
                chk("wrap first addr", bus1.ImemAddr, 32'hFFFF_FFFC);
            end
            if (i == 1) begin
                chk("wrap pcp4", bus1.PcPlus4Out, 32'h0);
                chk("wrap next addr", bus1.ImemAddr, 32'h0);
                chk("wrap valid", 32'(bus1.InstrValid), 32'h1);
                chk("wrap instr", bus1.InstrOut, memw(32'hFFFF_FFFC));
            end
        end

        // Reset pulsed while in HOLD.
        drive0(1'b1, 1'b1, 1'b0, 32'h0);
        @(posedge Clk);
        #1;
        chk("pre-reset hold req", 32'(bus0.ImemReq), 32'h0);
        Reset0 = 1'b1;
        #1;
        chk_reset0("async reset");
        drive0(1'b1, 1'b0, 1'b0, 32'h0);
        @(posedge Clk);
        #1;
        chk_reset0("reset held");
        Reset0 = 1'b0;
        @(posedge Clk);
        #1;
        chk("restart req", 32'(bus0.ImemReq), 32'h1);
        chk("restart addr", bus0.ImemAddr, 32'h0);
        @(posedge Clk);
        #1;
        chk("restart valid", 32'(bus0.InstrValid), 32'h1);
        chk("restart pcp4", bus0.PcPlus4Out, 32'h4);
        chk("restart instr", bus0.InstrOut, memw(32'h0));

        // Randomised run against the reference model.
        Reset0 = 1'b1;
        drive0(1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge Clk);
        #1;
        Reset0 = 1'b0;
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            rdy = ($urandom_range(0, 3) != 0);
            st  = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 15) == 0);
            tgt = $urandom;
            drive0(rdy, st, br, tgt);
            @(posedge Clk);
            model_step(rdy, st, br, tgt);
            #1;
            chk("rnd req",   32'(bus0.ImemReq), 32'(m_started && (m_buf.size() == 0)));
            chk("rnd addr",  bus0.ImemAddr, m_pc);
            chk("rnd valid", 32'(bus0.InstrValid), 32'(m_valid));
            chk("rnd instr", bus0.InstrOut, m_instr);
            chk("rnd opcode", 32'(bus0.OpcodeOut), 32'(m_instr[31:26]));
            if (m_valid)
                chk("rnd pcp4", bus0.PcPlus4Out, m_pcp4);
`ifdef IFETCH_PERF_EN
            chk("rnd fcount", bus0.FetchCount, m_fc);
            chk("rnd flcount", 32'(bus0.FlushCount), m_flc);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
